// File: rtl/seq_ctrl_pkg.sv
// Shared encodings for the accumulator-datapath instruction sequencer.
// Opcodes, ALU / accumulator-source selects and FSM state encoding.
package seq_ctrl_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_SUBI = 4'h3;
   localparam logic [3:0] OP_ANDI = 4'h4;
   localparam logic [3:0] OP_ORI  = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_BZ   = 4'h9;
   localparam logic [3:0] OP_MVR  = 4'hA;
   localparam logic [3:0] OP_MVA  = 4'hB;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [2:0] ALU_PASS = 3'd0;
   localparam logic [2:0] ALU_ADD  = 3'd1;
   localparam logic [2:0] ALU_SUB  = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;

   localparam logic [1:0] ACC_SRC_ALU = 2'd0;
   localparam logic [1:0] ACC_SRC_MEM = 2'd1;
   localparam logic [1:0] ACC_SRC_REG = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // ALU operation for the immediate-class opcodes
   function automatic logic [2:0] alu_of(input logic [3:0] op);
      logic [2:0] r;
      r = ALU_PASS;
      case (op)
         OP_ADDI: r = ALU_ADD;
         OP_SUBI: r = ALU_SUB;
         OP_ANDI: r = ALU_AND;
         OP_ORI:  r = ALU_OR;
         default: r = ALU_PASS;
      endcase
      return r;
   endfunction

   // True for opcodes whose effect is an accumulator ALU write
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_LDI) && (op <= OP_ORI);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait watchdog: counts consecutive stalled request cycles.
// timeout fires in the WAIT_MAX-th stalled cycle so the FSM can abort.
module mem_wait_timer #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

   logic [CW-1:0] cnt;

   assign timeout = active && !ready && (cnt == LAST);

   // Count stalled cycles; any ready, idle bus or abort restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!active || ready || timeout) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/instr_seq_ctrl.sv
// FETCH/DECODE/EXEC sequencer for the 16-bit accumulator datapath.
// Controls are decoded from the state and instruction registers.
import seq_ctrl_pkg::*;

module instr_seq_ctrl #(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      mem_rdata,
   input  logic             mem_ready,
   input  logic             acc_zero,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             pc_inc,
   output logic             pc_load,
   output logic [11:0]      imm12,
   output logic [2:0]       alu_op,
   output logic             acc_we,
   output logic [1:0]       acc_src,
   output logic             reg_we,
   output logic             busy,
   output logic             halted,
   output logic             illegal_op,
   output logic             bus_err,
   output logic [CNT_W-1:0] retired
);

   state_t      state;
   logic [15:0] ir;
   logic [3:0]  opc;
   logic        timeout;
   logic        retire;

   assign opc   = ir[15:12];
   assign imm12 = ir[11:0];

   mem_wait_timer #(
      .WAIT_MAX(WAIT_MAX)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .active (mem_req),
      .ready  (mem_ready),
      .timeout(timeout)
   );

   // Flag the transitions that complete an instruction
   always_comb begin
      retire = 1'b0;
      unique case (state)
         S_DECODE: retire = (opc == OP_NOP) || (opc == OP_HLT);
         S_EXEC:   retire = 1'b1;
         S_MEM:    retire = mem_ready && (opc == OP_ST);
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   // State, instruction register, sticky flags and retired counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ir         <= '0;
         retired    <= '0;
         illegal_op <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         if (retire) begin
            retired <= retired + 1'b1;
         end
         unique case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state      <= S_FETCH;
                  illegal_op <= 1'b0;
                  bus_err    <= 1'b0;
               end
            end
            S_FETCH: begin
               if (mem_ready) begin
                  ir    <= mem_rdata;
                  state <= S_DECODE;
               end else if (timeout) begin
                  bus_err <= 1'b1;
                  state   <= S_HALT;
               end
            end
            S_DECODE: begin
               case (opc)
                  OP_NOP:  state <= S_FETCH;
                  OP_LDI, OP_ADDI, OP_SUBI,
                  OP_ANDI, OP_ORI: state <= S_EXEC;
                  OP_LD, OP_ST:    state <= S_MEM;
                  OP_JMP, OP_BZ:   state <= S_EXEC;
                  OP_MVR, OP_MVA:  state <= S_EXEC;
                  OP_HLT:  state <= S_HALT;
                  default: begin
                     illegal_op <= 1'b1;
                     state      <= S_HALT;
                  end
               endcase
            end
            S_EXEC: state <= S_FETCH;
            S_MEM: begin
               if (mem_ready) begin
                  state <= (opc == OP_ST) ? S_FETCH : S_WB;
               end else if (timeout) begin
                  bus_err <= 1'b1;
                  state   <= S_HALT;
               end
            end
            S_WB:    state <= S_FETCH;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Control decode from state and IR; pc_inc and BZ follow live inputs
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      alu_op   = ALU_PASS;
      acc_we   = 1'b0;
      acc_src  = ACC_SRC_ALU;
      reg_we   = 1'b0;
      busy     = 1'b1;
      halted   = 1'b0;
      unique case (state)
         S_IDLE: busy = 1'b0;
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         S_FETCH: begin
            mem_req = 1'b1;
            pc_inc  = mem_ready;
         end
         S_DECODE: ;
         S_EXEC: begin
            unique case (1'b1)
               is_alu_op(opc): begin
                  acc_we  = 1'b1;
                  acc_src = ACC_SRC_ALU;
                  alu_op  = alu_of(opc);
               end
               (opc == OP_JMP): pc_load = 1'b1;
               (opc == OP_BZ):  pc_load = acc_zero;
               (opc == OP_MVR): reg_we  = 1'b1;
               (opc == OP_MVA): begin
                  acc_we  = 1'b1;
                  acc_src = ACC_SRC_REG;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opc == OP_ST);
         end
         S_WB: begin
            acc_we  = 1'b1;
            acc_src = ACC_SRC_MEM;
         end
         default: busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// Cycle-accurate scoreboard bench for instr_seq_ctrl.
// Expected control vectors are queued per instruction and popped per cycle.
module tb_instr_seq_ctrl;
   import seq_ctrl_pkg::*;

   localparam int WM = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [15:0]   mem_rdata;
   logic          mem_ready;
   logic          acc_zero;
   logic          mem_req, mem_we, addr_sel, pc_inc, pc_load;
   logic [11:0]   imm12;
   logic [2:0]    alu_op;
   logic          acc_we;
   logic [1:0]    acc_src;
   logic          reg_we, busy, halted, illegal_op, bus_err;
   logic [CW-1:0] retired;

   instr_seq_ctrl #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .acc_zero(acc_zero), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .pc_inc(pc_inc), .pc_load(pc_load),
      .imm12(imm12), .alu_op(alu_op), .acc_we(acc_we),
      .acc_src(acc_src), .reg_we(reg_we), .busy(busy),
      .halted(halted), .illegal_op(illegal_op),
      .bus_err(bus_err), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req, we, as, pinc, pld, awe;
      logic [1:0] src;
      logic [2:0] alu;
      logic       rwe, bsy, hlt;
   } ctl_t;

   typedef struct {
      ctl_t        exp;
      logic        rdy;
      logic [15:0] rdata;
   } step_t;

   step_t       sbq[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_ret = '0;
   ctl_t        obs;

   assign obs = {mem_req, mem_we, addr_sel, pc_inc, pc_load, acc_we,
                 acc_src, alu_op, reg_we, busy, halted};

   function automatic ctl_t v(input logic req, we, as, pinc, pld, awe,
                              input logic [1:0] src,
                              input logic [2:0] alu,
                              input logic rwe, bsy, hlt);
      ctl_t c;
      c = {req, we, as, pinc, pld, awe, src, alu, rwe, bsy, hlt};
      return c;
   endfunction

   function automatic ctl_t fe(input logic rdy);
      return v(1, 0, 0, rdy, 0, 0, 2'd0, 3'd0, 0, 1, 0);
   endfunction

   function automatic ctl_t memv(input logic st);
      return v(1, st, 1, 0, 0, 0, 2'd0, 3'd0, 0, 1, 0);
   endfunction

   localparam ctl_t DEC   = 13'b0_0_0_0_0_0_00_000_0_1_0;
   localparam ctl_t HALTV = 13'b0_0_0_0_0_0_00_000_0_0_1;
   localparam ctl_t IDLEV = 13'b0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input ctl_t e, input logic r, input logic [15:0] d);
      step_t s;
      s.exp   = e;
      s.rdy   = r;
      s.rdata = d;
      sbq.push_back(s);
   endtask

   // Queue the expected per-cycle controls of one instruction
   task automatic push_instr(input logic [15:0] ins, input int fw,
                             input int mw, input logic az);
      logic [3:0] op;
      op = ins[15:12];
      for (int i = 0; i < fw; i++) push(fe(0), 0, 16'hDEAD);
      push(fe(1), 1, ins);
      push(DEC, 0, 16'h0);
      case (op)
         4'h0: exp_ret++;
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            push(v(0, 0, 0, 0, 0, 1, 2'd0, 3'(op - 4'd1), 0, 1, 0),
                 0, 16'h0);
            exp_ret++;
         end
         4'h6: begin
            for (int i = 0; i < mw; i++) push(memv(0), 0, 16'h0);
            push(memv(0), 1, 16'h5A5A);
            push(v(0, 0, 0, 0, 0, 1, 2'd1, 3'd0, 0, 1, 0), 0, 16'h0);
            exp_ret++;
         end
         4'h7: begin
            for (int i = 0; i < mw; i++) push(memv(1), 0, 16'h0);
            push(memv(1), 1, 16'h0);
            exp_ret++;
         end
         4'h8: begin
            push(v(0, 0, 0, 0, 1, 0, 2'd0, 3'd0, 0, 1, 0), 0, 16'h0);
            exp_ret++;
         end
         4'h9: begin
            push(v(0, 0, 0, 0, az, 0, 2'd0, 3'd0, 0, 1, 0), 0, 16'h0);
            exp_ret++;
         end
         4'hA: begin
            push(v(0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1, 1, 0), 0, 16'h0);
            exp_ret++;
         end
         4'hB: begin
            push(v(0, 0, 0, 0, 0, 1, 2'd2, 3'd0, 0, 1, 0), 0, 16'h0);
            exp_ret++;
         end
         4'hF: begin
            push(HALTV, 0, 16'h0);
            exp_ret++;
         end
         default: push(HALTV, 0, 16'h0);
      endcase
   endtask

   // Pop the scoreboard one cycle at a time and compare controls
   task automatic drain(input string name);
      step_t s;
      int    n;
      n = 0;
      while (sbq.size() > 0) begin
         s = sbq.pop_front();
         mem_ready = s.rdy;
         mem_rdata = s.rdata;
         #1;
         checks++;
         if (obs !== s.exp) begin
            errors++;
            $display("FAIL %s cycle %0d: ctl got %b expected %b",
                     name, n, obs, s.exp);
         end
         n++;
         cyc();
      end
      mem_ready = 1'b0;
   endtask

   task automatic run(input string name, input logic [15:0] ins,
                      input int fw, input int mw, input logic az);
      acc_zero = az;
      push_instr(ins, fw, mw, az);
      drain(name);
      checks++;
      if (imm12 !== ins[11:0]) begin
         errors++;
         $display("FAIL %s imm12: got %h expected %h",
                  name, imm12, ins[11:0]);
      end
      checks++;
      if (retired !== exp_ret) begin
         errors++;
         $display("FAIL %s retired: got %0d expected %0d",
                  name, retired, exp_ret);
      end
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      acc_zero  = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      checks++;
      if (obs !== IDLEV) begin
         errors++;
         $display("FAIL reset ctl: got %b expected %b", obs, IDLEV);
      end
      checks++;
      if ({retired, imm12, illegal_op, bus_err} !== '0) begin
         errors++;
         $display("FAIL reset regs: got %h/%h/%b/%b expected zero",
                  retired, imm12, illegal_op, bus_err);
      end
   endtask

   task automatic test_ldi();
      do_start();
      run("ldi", 16'h1ABC, 0, 0, 0);
   endtask

   task automatic test_alu();
      run("addi", 16'h2005, 1, 0, 0);
      run("subi", 16'h3001, 0, 0, 0);
      run("andi", 16'h40F0, 2, 0, 0);
      run("ori",  16'h5003, 0, 0, 0);
   endtask

   task automatic test_mem();
      run("ld_wait3", 16'h6123, 0, 3, 0);
      run("st",       16'h7010, 0, 0, 0);
      run("st_wait2", 16'h7020, 1, 2, 0);
   endtask

   task automatic test_bz();
      run("bz_taken", 16'h9040, 0, 0, 1);
      run("bz_not",   16'h9040, 0, 0, 0);
   endtask

   task automatic test_misc();
      run("jmp", 16'h8100, 0, 0, 0);
      run("mvr", 16'hA003, 0, 0, 0);
      run("mva", 16'hB004, 0, 0, 0);
      run("nop", 16'h0000, 0, 0, 0);
   endtask

   task automatic test_back_to_back();
      start = 1'b1;
      run("b2b_ldi", 16'h1001, 0, 0, 0);
      run("b2b_ld",  16'h6002, 0, 0, 0);
      run("b2b_st",  16'h7003, 0, 1, 0);
      start = 1'b0;
   endtask

   task automatic test_illegal();
      run("illegal", 16'hD000, 0, 0, 0);
      checks++;
      if (illegal_op !== 1'b1) begin
         errors++;
         $display("FAIL illegal flag: got %b expected 1", illegal_op);
      end
      do_start();
      checks++;
      if (illegal_op !== 1'b0 || mem_req !== 1'b1) begin
         errors++;
         $display("FAIL illegal restart: got flag=%b req=%b expected 0/1",
                  illegal_op, mem_req);
      end
      run("after_illegal", 16'h1005, 0, 0, 0);
   endtask

   task automatic test_hlt();
      run("hlt", 16'hF000, 0, 0, 0);
      do_start();
      run("after_hlt", 16'h2001, 0, 0, 0);
   endtask

   task automatic test_bus_err();
      for (int i = 0; i < WM; i++) push(fe(0), 0, 16'h0);
      push(HALTV, 0, 16'h0);
      drain("bus_err");
      checks++;
      if (bus_err !== 1'b1 || retired !== exp_ret) begin
         errors++;
         $display("FAIL bus_err flag: got %b ret=%0d expected 1 ret=%0d",
                  bus_err, retired, exp_ret);
      end
      do_start();
      checks++;
      if (bus_err !== 1'b0) begin
         errors++;
         $display("FAIL bus_err clear: got %b expected 0", bus_err);
      end
      run("after_bus_err", 16'h3002, 0, 0, 0);
   endtask

   task automatic test_reset_mid();
      push(fe(1), 1, 16'h7FFF);
      push(DEC, 0, 16'h0);
      push(memv(1), 0, 16'h0);
      drain("st_pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== IDLEV || retired !== '0 || imm12 !== '0) begin
         errors++;
         $display("FAIL async reset: got %b ret=%0d imm=%h expected 0",
                  obs, retired, imm12);
      end
      exp_ret = '0;
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      checks++;
      if (obs !== IDLEV) begin
         errors++;
         $display("FAIL idle after reset: got %b expected %b", obs, IDLEV);
      end
      do_start();
      run("resume", 16'h1111, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_alu();
      test_mem();
      test_bz();
      test_misc();
      test_back_to_back();
      test_illegal();
      test_hlt();
      test_bus_err();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
